// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the write-back stage.
// Optional feature macro used by this block: WB_PERF_CNT_EN (retire counter).
package wb_stage_pkg;

  localparam int WREG_W     = 6;          // destination field incl. non-GPR select bit
  localparam int GPR_ADDR_W = 5;          // architectural GPR index width
  localparam int NONGPR_BIT = 5;          // wreg bit that steers to a non-GPR target
  localparam int XLEN       = 32;
  localparam logic [XLEN-1:0] AL_OFFSET = 32'd8;  // link value = pc + 8 (past delay slot)

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [WREG_W-1:0] wreg_t;

  // Source of the GPR write data, in decreasing priority
  typedef enum logic [2:0] {
    SRC_LOAD,
    SRC_LINK,
    SRC_HI,
    SRC_LO,
    SRC_RES
  } wdata_src_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline register fields feeding the write-back stage.
interface wb_stage_if;
  import wb_stage_pkg::*;

  word_t       wb_pc;
  word_t       wb_res;
  word_t       wb_hi;
  word_t       wb_lo;
  word_t       wb_rdata;
  logic        wb_load;
  logic        wb_al;
  logic        wb_regwen;
  wreg_t       wb_wreg;
  logic [1:0]  wb_rhilo;
  logic [1:0]  wb_whilo;

  modport master (
    output wb_pc, wb_res, wb_hi, wb_lo, wb_rdata, wb_load, wb_al,
           wb_regwen, wb_wreg, wb_rhilo, wb_whilo
  );

  modport slave (
    input  wb_pc, wb_res, wb_hi, wb_lo, wb_rdata, wb_load, wb_al,
           wb_regwen, wb_wreg, wb_rhilo, wb_whilo
  );

endinterface

// File: rtl/wb_stage_hilo_reg.sv
// HI/LO architected registers with same-cycle bypass of pending writes.
module hilo_reg
  import wb_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] whilo,
  input  word_t      hi_in,
  input  word_t      lo_in,
  output word_t      hi_q,
  output word_t      lo_q,
  output word_t      hi_fwd,
  output word_t      lo_fwd
);

  // Storage: each half loads independently; reset wins over any write
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (whilo[1]) hi_q <= hi_in;
      if (whilo[0]) lo_q <= lo_in;
    end
  end

  // Bypass: EX sees the value being written this cycle before it lands
  always_comb begin
    hi_fwd = whilo[1] ? hi_in : hi_q;
    lo_fwd = whilo[0] ? lo_in : lo_q;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: GPR write port, HI/LO state, trace outputs.
// Define WB_PERF_CNT_EN to add the retired-instruction counter (retire_cnt).
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  wb_stage_if.slave             wb,
  output logic                  rf_wen,
  output logic [GPR_ADDR_W-1:0] rf_waddr,
  output word_t                 rf_wdata,
  output word_t                 hi_q,
  output word_t                 lo_q,
  output word_t                 hi_fwd,
  output word_t                 lo_fwd,
  output word_t                 debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [GPR_ADDR_W-1:0] debug_wb_rf_wnum,
`ifdef WB_PERF_CNT_EN
  output word_t                 debug_wb_rf_wdata,
  output word_t                 retire_cnt
`else
  output word_t                 debug_wb_rf_wdata
`endif
);

  wdata_src_e src;

  hilo_reg u_hilo (
    .clk    (clk),
    .reset  (reset),
    .whilo  (wb.wb_whilo),
    .hi_in  (wb.wb_hi),
    .lo_in  (wb.wb_lo),
    .hi_q   (hi_q),
    .lo_q   (lo_q),
    .hi_fwd (hi_fwd),
    .lo_fwd (lo_fwd)
  );

  // Write-data source priority: load > link > HI read > LO read > ALU result.
  // HI/LO reads use the registered value, so a same-cycle write is not visible.
  always_comb begin
    if (wb.wb_load)          src = SRC_LOAD;
    else if (wb.wb_al)       src = SRC_LINK;
    else if (wb.wb_rhilo[1]) src = SRC_HI;
    else if (wb.wb_rhilo[0]) src = SRC_LO;
    else                     src = SRC_RES;
  end

  // Write-data mux
  always_comb begin
    unique case (src)
      SRC_LOAD: rf_wdata = wb.wb_rdata;
      SRC_LINK: rf_wdata = wb.wb_pc + AL_OFFSET;
      SRC_HI:   rf_wdata = hi_q;
      SRC_LO:   rf_wdata = lo_q;
      default:  rf_wdata = wb.wb_res;
    endcase
  end

  // GPR write enable: drop writes to $0 and to non-GPR destinations
  always_comb begin
    rf_waddr = wb.wb_wreg[GPR_ADDR_W-1:0];
    rf_wen   = wb.wb_regwen & ~wb.wb_wreg[NONGPR_BIT] & (rf_waddr != '0);
  end

  // Trace port mirrors the commit
  always_comb begin
    debug_wb_pc       = wb.wb_pc;
    debug_wb_rf_wen   = {4{rf_wen}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

`ifdef WB_PERF_CNT_EN
  // Retire counter: every non-bubble cycle retires one instruction; wraps freely
  always_ff @(posedge clk) begin
    if (reset)                retire_cnt <= '0;
    else if (wb.wb_pc != '0)  retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// traffic against a behavioural model of HI/LO, GPR write and retire count.
`timescale 1ns/1ps
module tb_wb_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_stage_if bus ();

  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_q, lo_q, hi_fwd, lo_fwd;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_cnt;
`endif

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .wb                (bus),
    .rf_wen            (rf_wen),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .hi_q              (hi_q),
    .lo_q              (lo_q),
    .hi_fwd            (hi_fwd),
    .lo_fwd            (lo_fwd),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
`ifdef WB_PERF_CNT_EN
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .retire_cnt        (retire_cnt)
`else
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [31:0] m_hi, m_lo, m_cnt;

  // Expected GPR write data from the architectural rules
  function automatic logic [31:0] ref_wdata();
    if (bus.wb_load)          return bus.wb_rdata;
    if (bus.wb_al)            return bus.wb_pc + 32'd8;
    if (bus.wb_rhilo[1])      return m_hi;
    if (bus.wb_rhilo[0])      return m_lo;
    return bus.wb_res;
  endfunction

  // Writes land only in GPRs 1..31
  function automatic logic ref_wen();
    int d;
    d = int'(bus.wb_wreg);
    return bus.wb_regwen && d >= 1 && d <= 31;
  endfunction

  task automatic clear_fields();
    bus.wb_pc = '0; bus.wb_res = '0; bus.wb_hi = '0; bus.wb_lo = '0;
    bus.wb_rdata = '0; bus.wb_load = 1'b0; bus.wb_al = 1'b0;
    bus.wb_regwen = 1'b0; bus.wb_wreg = '0; bus.wb_rhilo = '0; bus.wb_whilo = '0;
  endtask

  // Advance one edge, updating the model with what the edge should do
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_hi = '0; m_lo = '0; m_cnt = '0;
    end else begin
      if (bus.wb_whilo[1]) m_hi = bus.wb_hi;
      if (bus.wb_whilo[0]) m_lo = bus.wb_lo;
      if (bus.wb_pc != 0) m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_fields();
    bus.wb_whilo = 2'b11; bus.wb_hi = 32'h1234; bus.wb_lo = 32'h5678;
    tick(); tick();
    tests++; if (hi_q !== 32'h0) begin fails++; $display("FAIL reset_hi got %h exp %h", hi_q, 32'h0); end
    tests++; if (lo_q !== 32'h0) begin fails++; $display("FAIL reset_lo got %h exp %h", lo_q, 32'h0); end
    bus.wb_whilo = 2'b00;
    bus.wb_load = 1'b1; bus.wb_rdata = 32'hCAFE_F00D; bus.wb_regwen = 1'b0; bus.wb_wreg = 6'd7;
    #1;
    tests++; if (rf_wdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL reset_comb_wdata got %h exp %h", rf_wdata, 32'hCAFE_F00D); end
    tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL reset_wen got %b exp 0", rf_wen); end
`ifdef WB_PERF_CNT_EN
    tests++; if (retire_cnt !== 32'h0) begin fails++; $display("FAIL reset_cnt got %h exp 0", retire_cnt); end
`endif
    clear_fields();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_load();
    clear_fields();
    bus.wb_pc = 32'hBFC0_0000; bus.wb_load = 1'b1; bus.wb_rdata = 32'hDEAD_BEEF;
    bus.wb_regwen = 1'b1; bus.wb_wreg = 6'h03; bus.wb_rhilo = 2'b11; bus.wb_res = 32'h1;
    #1;
    tests++; if (rf_wen !== 1'b1) begin fails++; $display("FAIL load_wen got %b exp 1", rf_wen); end
    tests++; if (rf_waddr !== 5'd3) begin fails++; $display("FAIL load_waddr got %0d exp 3", rf_waddr); end
    tests++; if (rf_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_wdata got %h exp deadbeef", rf_wdata); end
    tests++; if (debug_wb_rf_wen !== 4'hF) begin fails++; $display("FAIL load_dbg_wen got %h exp f", debug_wb_rf_wen); end
    tests++; if (debug_wb_pc !== 32'hBFC0_0000 || debug_wb_rf_wnum !== 5'd3 || debug_wb_rf_wdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL load_trace got pc=%h wnum=%0d wdata=%h", debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    tick();
  endtask

  task automatic test_link();
    clear_fields();
    bus.wb_pc = 32'hBFC0_0100; bus.wb_al = 1'b1; bus.wb_regwen = 1'b1; bus.wb_wreg = 6'h1F;
    bus.wb_res = 32'h5; bus.wb_rhilo = 2'b10;
    #1;
    tests++; if (rf_wdata !== 32'hBFC0_0108) begin fails++; $display("FAIL link_wdata got %h exp bfc00108", rf_wdata); end
    tests++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd31) begin fails++; $display("FAIL link_wen got %b/%0d exp 1/31", rf_wen, rf_waddr); end
    bus.wb_pc = 32'hFFFF_FFFC;
    #1;
    tests++; if (rf_wdata !== 32'h0000_0004) begin fails++; $display("FAIL link_wrap got %h exp 00000004", rf_wdata); end
    tick();
  endtask

  task automatic test_zero_nongpr();
    clear_fields();
    bus.wb_pc = 32'h100; bus.wb_regwen = 1'b1; bus.wb_res = 32'h77; bus.wb_wreg = 6'h00;
    #1;
    tests++; if (rf_wen !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin fails++; $display("FAIL zero_reg got %b/%h exp 0/0", rf_wen, debug_wb_rf_wen); end
    bus.wb_wreg = 6'h25;
    #1;
    tests++; if (rf_wen !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin fails++; $display("FAIL nongpr got %b/%h exp 0/0", rf_wen, debug_wb_rf_wen); end
    tests++; if (rf_waddr !== 5'd5) begin fails++; $display("FAIL nongpr_waddr got %0d exp 5", rf_waddr); end
    tick();
  endtask

  task automatic test_hilo();
    clear_fields();
    bus.wb_pc = 32'h200; bus.wb_whilo = 2'b11; bus.wb_hi = 32'hAAAA; bus.wb_lo = 32'hBBBB;
    tick();
    bus.wb_pc = 32'h204; bus.wb_hi = 32'h11; bus.wb_lo = 32'h22; bus.wb_rhilo = 2'b10;
    bus.wb_regwen = 1'b1; bus.wb_wreg = 6'd2;
    #1;
    tests++; if (rf_wdata !== 32'hAAAA) begin fails++; $display("FAIL hilo_old_read got %h exp aaaa", rf_wdata); end
    tests++; if (hi_fwd !== 32'h11 || lo_fwd !== 32'h22) begin fails++; $display("FAIL hilo_fwd got %h/%h exp 11/22", hi_fwd, lo_fwd); end
    tests++; if (hi_q !== 32'hAAAA) begin fails++; $display("FAIL hilo_pre got %h exp aaaa", hi_q); end
    tick();
    bus.wb_whilo = 2'b00; bus.wb_hi = 32'h99; bus.wb_lo = 32'h98; bus.wb_rhilo = 2'b01;
    #1;
    tests++; if (hi_q !== 32'h11 || lo_q !== 32'h22) begin fails++; $display("FAIL hilo_post got %h/%h exp 11/22", hi_q, lo_q); end
    tests++; if (hi_fwd !== 32'h11 || lo_fwd !== 32'h22) begin fails++; $display("FAIL hilo_hold_fwd got %h/%h exp 11/22", hi_fwd, lo_fwd); end
    tests++; if (rf_wdata !== 32'h22) begin fails++; $display("FAIL lo_read got %h exp 22", rf_wdata); end
    // single-half write leaves the other half alone
    bus.wb_whilo = 2'b01; bus.wb_lo = 32'h3333;
    tick();
    tests++; if (hi_q !== 32'h11 || lo_q !== 32'h3333) begin fails++; $display("FAIL lo_only got %h/%h exp 11/3333", hi_q, lo_q); end
  endtask

  task automatic test_reset_mid();
    clear_fields();
    bus.wb_pc = 32'h300; bus.wb_whilo = 2'b10; bus.wb_hi = 32'h55;
    tick();
    tests++; if (hi_q !== 32'h55) begin fails++; $display("FAIL mid_pre got %h exp 55", hi_q); end
    bus.wb_hi = 32'h66; reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (hi_q !== 32'h0) begin fails++; $display("FAIL mid_reset_hi got %h exp 0", hi_q); end
`ifdef WB_PERF_CNT_EN
    tests++; if (retire_cnt !== 32'h0) begin fails++; $display("FAIL mid_reset_cnt got %h exp 0", retire_cnt); end
`endif
    clear_fields();
  endtask

  task automatic test_random();
    int pick;
    for (int i = 0; i < 300; i++) begin
      clear_fields();
      if ($urandom_range(0, 7) != 0) begin
        bus.wb_pc     = $urandom() & 32'hFFFF_FFFC;
        bus.wb_res    = $urandom();
        bus.wb_hi     = $urandom();
        bus.wb_lo     = $urandom();
        bus.wb_rdata  = $urandom();
        pick          = int'($urandom_range(0, 3));
        bus.wb_load   = (pick == 0);
        bus.wb_al     = (pick == 1) || ($urandom_range(0, 5) == 0);
        bus.wb_regwen = $urandom_range(0, 3) != 0;
        bus.wb_wreg   = 6'($urandom_range(0, 63));
        bus.wb_rhilo  = 2'($urandom_range(0, 3));
        bus.wb_whilo  = 2'($urandom_range(0, 3));
      end
      #1;
      tests++;
      if (rf_wdata !== ref_wdata() || rf_wen !== ref_wen() || rf_waddr !== bus.wb_wreg[4:0]
          || debug_wb_rf_wen !== {4{ref_wen()}} || debug_wb_rf_wdata !== ref_wdata()) begin
        fails++;
        $display("FAIL rand_comb[%0d] got wen=%b wdata=%h exp wen=%b wdata=%h", i, rf_wen, rf_wdata, ref_wen(), ref_wdata());
      end
      tests++;
      if (hi_fwd !== (bus.wb_whilo[1] ? bus.wb_hi : m_hi) || lo_fwd !== (bus.wb_whilo[0] ? bus.wb_lo : m_lo)) begin
        fails++; $display("FAIL rand_fwd[%0d] got %h/%h", i, hi_fwd, lo_fwd);
      end
      tick();
      tests++;
      if (hi_q !== m_hi || lo_q !== m_lo) begin
        fails++; $display("FAIL rand_hilo[%0d] got %h/%h exp %h/%h", i, hi_q, lo_q, m_hi, m_lo);
      end
`ifdef WB_PERF_CNT_EN
      tests++;
      if (retire_cnt !== m_cnt) begin fails++; $display("FAIL rand_cnt[%0d] got %h exp %h", i, retire_cnt, m_cnt); end
`endif
    end
  endtask

`ifdef WB_PERF_CNT_EN
  task automatic test_counter_wrap();
    clear_fields();
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    m_cnt = 32'hFFFF_FFFF;
    tick();
    tests++; if (retire_cnt !== 32'hFFFF_FFFF) begin fails++; $display("FAIL cnt_bubble got %h exp ffffffff", retire_cnt); end
    bus.wb_pc = 32'h400;
    tick();
    tests++; if (retire_cnt !== 32'h0) begin fails++; $display("FAIL cnt_wrap got %h exp 0", retire_cnt); end
    clear_fields();
  endtask
`endif

  initial begin
    reset = 1'b1;
    m_hi = '0; m_lo = '0; m_cnt = '0;
    clear_fields();
    #1;
    test_reset();
    test_load();
    test_link();
    test_zero_nongpr();
    test_hilo();
    test_reset_mid();
    test_random();
`ifdef WB_PERF_CNT_EN
    test_counter_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide inputs: wb_pc 32, wb_res 32, wb_hi 32, wb_lo 32, wb_rdata 32, wb_load 1, wb_al 1, wb_regwen 1, wb_wreg 6, wb_rhilo 2, wb_whilo 2; meaning: registered MEM/WB fields.
REQ-004 SHALL provide outputs: rf_wen 1, rf_waddr 5, rf_wdata 32; meaning: GPR write port.
REQ-005 SHALL provide outputs: hi_q 32, lo_q 32; meaning: architected HI/LO registers.
REQ-006 SHALL provide outputs: hi_fwd 32, lo_fwd 32; meaning: HI/LO bypass to EX.
REQ-007 SHALL provide outputs: debug_wb_pc 32, debug_wb_rf_wen 4, debug_wb_rf_wnum 5, debug_wb_rf_wdata 32; meaning: trace.
REQ-008 SHALL provide output retire_cnt 32 (only with WB_PERF_CNT_EN); meaning: retired-instruction count.

Function
REQ-009 rf_wdata SHALL be selected by fixed priority: wb_load -> wb_rdata; wb_al -> wb_pc+8 (mod 2^32); wb_rhilo[1] -> hi_q; wb_rhilo[0] -> lo_q; otherwise wb_res.
REQ-010 rf_wen SHALL equal wb_regwen & ~wb_wreg[5] & (wb_wreg[4:0] != 0); writes to $0 or wreg[5]=1 (non-GPR) are suppressed.
REQ-011 rf_waddr SHALL equal wb_wreg[4:0], combinationally, zero latency.
REQ-012 On a rising edge without reset, hi_q SHALL load wb_hi if wb_whilo[1]; lo_q SHALL load wb_lo if wb_whilo[0]; otherwise both hold.
REQ-013 hi_fwd SHALL be wb_whilo[1] ? wb_hi : hi_q; lo_fwd likewise with wb_whilo[0]/wb_lo/lo_q.
REQ-014 Simultaneous wb_rhilo and wb_whilo SHALL read the pre-update hi_q/lo_q; update takes effect next cycle.
REQ-015 debug_wb_pc SHALL equal wb_pc; debug_wb_rf_wen SHALL be {4{rf_wen}}; wnum/wdata SHALL mirror rf_waddr/rf_wdata.
REQ-016 A bubble is any cycle with wb_pc == 0; bubbles SHALL produce no effects beyond those implied by their (zero) control fields.

Reset
REQ-017 While reset is high at a rising edge, hi_q, lo_q and retire_cnt SHALL become 0.
REQ-018 Reset SHALL take precedence over simultaneous whilo writes and counter increments.
REQ-019 Combinational outputs SHALL follow inputs during reset; with zeroed upstream fields rf_wen is 0.

Configuration
REQ-020 Macro WB_PERF_CNT_EN SHALL gate the retire counter.
REQ-021 With WB_PERF_CNT_EN defined, retire_cnt SHALL increment by 1 each non-reset edge where wb_pc != 0, wrapping 0xFFFFFFFF -> 0.
REQ-022 Without WB_PERF_CNT_EN, port retire_cnt and its register SHALL be absent.

Structure
REQ-023 Shared package SHALL hold: wreg field widths, the GPR/non-GPR select bit index (5), and the AL link offset constant (8).
REQ-024 One sub-module, hilo_reg (HI/LO storage plus bypass), SHALL implement REQ-012 through REQ-014; the rest of the block is flat.

Verification
REQ-025 Load: load=1, rdata=0xDEADBEEF, regwen=1, wreg=0x03 -> rf_wen=1, waddr=3, wdata=0xDEADBEEF, debug_wb_rf_wen=0xF.
REQ-026 Link: al=1, pc=0xBFC00100, wreg=0x1F -> wdata=0xBFC00108; pc=0xFFFFFFFC -> wdata=0x00000004.
REQ-027 $0 and non-GPR: regwen=1 with wreg=0x00 and with wreg=0x25 -> rf_wen=0, debug_wb_rf_wen=0.
REQ-028 HI/LO: whilo=2'b11, hi=0x11, lo=0x22 with rhilo=2'b10 in the same cycle -> wdata=old hi_q, hi_fwd=0x11; next cycle hi_q=0x11, lo_q=0x22.
REQ-029 Reset mid-operation: hi_q=0x55 with whilo=2'b10 and reset=1 at the same edge -> hi_q=0, retire_cnt=0.
REQ-030 Counter (WB_PERF_CNT_EN): preload via 0xFFFFFFFF non-bubble cycles, or force the value -> next valid cycle gives 0; a pc=0 cycle leaves the count unchanged.
